// File: rtl/ascii_number_stream_parser_pkg.sv
// Shared definitions for the ASCII number stream parser: character codes,
// FSM state encoding and the byte classifier used while scanning a word.
package ascii_number_stream_parser_pkg;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_NUL = 8'h00;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  typedef enum logic [1:0] {BC_DIGIT, BC_IGNORE, BC_SEP} byte_class_t;

  // NUL padding and CR are transparent; anything that is not a digit ends a number.
  function automatic byte_class_t classify_byte(input logic [7:0] b);
    if (b >= CH_0 && b <= CH_9) return BC_DIGIT;
    if (b == CH_NUL || b == CH_CR) return BC_IGNORE;
    if (b == CH_LF) return BC_SEP;
    return BC_SEP;
  endfunction

endpackage

// File: rtl/ascii_number_stream_parser_decimal_accumulator.sv
// Combinational acc*10+digit step, evaluated four bits wider than the
// accumulator so any bit spilling above NUM_W is reported as carry.
module decimal_accumulator #(
  parameter int NUM_W = 64
) (
  input  logic [NUM_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [NUM_W-1:0] next_acc,
  output logic             carry
);

  logic [NUM_W+3:0] acc_ext;
  logic [NUM_W+3:0] wide;

  assign acc_ext  = {4'b0000, acc};
  assign wide     = (acc_ext << 3) + (acc_ext << 1) + {{NUM_W{1'b0}}, digit};
  assign next_acc = wide[NUM_W-1:0];
  assign carry    = |wide[NUM_W+3:NUM_W];

endmodule

// File: rtl/ascii_number_stream_parser.sv
// Scans packed 8-character words one byte per cycle and emits each decimal
// number found on a valid/ready output, with sticky overflow and end-of-input flush.
module ascii_number_stream_parser
  import ascii_number_stream_parser_pkg::*;
#(
  parameter int    UUID  = 0,
  parameter string NAME  = "",
  parameter int    NUM_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_word,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_number,
  output logic             out_overflow,
  output logic             done
);

  state_t           state;
  logic [2:0]       idx;
  logic [NUM_W-1:0] acc;
  logic             has_digits;
  logic             ovf;
  logic [63:0]      word;
  logic             last;

  logic [7:0]       cur_byte;
  byte_class_t      cls;
  logic [NUM_W-1:0] next_acc;
  logic             carry;
  logic             has_after;
  logic             emit_now;

  assign cur_byte = word[{idx, 3'b000} +: 8];
  assign cls      = classify_byte(cur_byte);

  // Low nibble of '0'..'9' equals byte - CH_0.
  decimal_accumulator #(.NUM_W(NUM_W)) u_acc (
    .acc      (acc),
    .digit    (cur_byte[3:0]),
    .next_acc (next_acc),
    .carry    (carry)
  );

  // A number closes on a separator, or on the final byte of the last word.
  assign has_after = has_digits | (cls == BC_DIGIT);
  assign emit_now  = ((cls == BC_SEP) && has_digits) ||
                     ((idx == 3'd7) && last && has_after);

  assign out_number   = acc;
  assign out_overflow = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      acc        <= '0;
      has_digits <= 1'b0;
      ovf        <= 1'b0;
      word       <= '0;
      last       <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      idx        <= 3'd0;
      acc        <= '0;
      has_digits <= 1'b0;
      ovf        <= 1'b0;
      word       <= '0;
      last       <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word     <= in_word;
            last     <= in_last;
            idx      <= 3'd0;
            state    <= SCAN;
            in_ready <= 1'b0;
          end
        end
        SCAN: begin
          if (cls == BC_DIGIT) begin
            acc        <= next_acc;
            has_digits <= 1'b1;
            ovf        <= ovf | carry;
          end
          if (emit_now) begin
            state     <= EMIT;
            out_valid <= 1'b1;
          end else if (idx == 3'd7) begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end else begin
            idx <= idx + 3'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            acc        <= '0;
            has_digits <= 1'b0;
            ovf        <= 1'b0;
            out_valid  <= 1'b0;
            if (idx == 3'd7) begin
              if (last) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= IDLE;
                in_ready <= 1'b1;
              end
            end else begin
              state <= SCAN;
              idx   <= idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_number_stream_parser.sv
// Scoreboard bench: stimulus pushes expected numbers, a negedge monitor pops
// and compares them on every accepted output.
module tb_ascii_number_stream_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_word = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_number;
  logic        out_overflow;
  logic        done;

  typedef struct {
    logic [63:0] num;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ascii_number_stream_parser #(.UUID(0), .NAME("dut"), .NUM_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_number   (out_number),
    .out_overflow (out_overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0d, expected no output", out_number);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_number", out_number, e.num);
        check("out_overflow", {63'd0, out_overflow}, {63'd0, e.ovf});
      end
    end
  end

  task automatic push_exp(input logic [63:0] num, input logic ovf);
    exp_t e;
    e.num = num;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [63:0] w, input logic l);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    in_word  = w;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!((in_ready || done) && sb.size() == 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 1);
    check("rst_out_valid", {63'd0, out_valid}, 0);
    check("rst_out_number", out_number, 0);
    check("rst_done", {63'd0, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // "12\n": separator at byte 2 is processed on the third edge after accept
    push_exp(64'd12, 1'b0);
    send_word(64'h0000_0000_000A_3231, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_latency_valid", {63'd0, out_valid}, 1);
    check("t1_latency_number", out_number, 64'd12);
    wait_idle();

    // "1969" spanning into a word holding only '\n'
    push_exp(64'd1969, 1'b0);
    send_word(64'h0000_0000_3936_3931, 1'b0);
    send_word(64'h0000_0000_0000_000A, 1'b0);
    wait_idle();

    // "14\n" under backpressure
    out_ready = 1'b0;
    push_exp(64'd14, 1'b0);
    send_word(64'h0000_0000_000A_3431, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {63'd0, out_valid}, 1);
      check("t3_hold_number", out_number, 64'd14);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // "100756" in the last word with no newline: flushed, then DONE
    push_exp(64'd100756, 1'b0);
    send_word(64'h0000_3635_3730_3031, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("t4_done", {63'd0, done}, 1);
    check("t4_in_ready", {63'd0, in_ready}, 0);
    check("t4_out_valid", {63'd0, out_valid}, 0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("t4_clear_done", {63'd0, done}, 0);
    check("t4_clear_in_ready", {63'd0, in_ready}, 1);

    // clear together with in_valid: the word is dropped
    in_word  = 64'h0000_0000_0000_0A35;
    in_last  = 1'b0;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("clr_drop_in_ready", {63'd0, in_ready}, 1);

    // 21 nines wrap: (10^21 - 1) mod 2^64, then "7\n" with overflow cleared
    push_exp(64'd3875820019684212735, 1'b1);
    send_word(64'h3939_3939_3939_3939, 1'b0);
    send_word(64'h3939_3939_3939_3939, 1'b0);
    send_word(64'h0000_0A39_3939_3939, 1'b0);
    push_exp(64'd7, 1'b0);
    send_word(64'h0000_0000_0000_0A37, 1'b0);
    wait_idle();

    // reset while scanning byte 3 of "4567\n"
    send_word(64'h0000_000A_3736_3534, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", {63'd0, out_valid}, 0);
    check("t6_rst_out_number", out_number, 0);
    check("t6_rst_overflow", {63'd0, out_overflow}, 0);
    check("t6_rst_done", {63'd0, done}, 0);
    check("t6_rst_in_ready", {63'd0, in_ready}, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_exp(64'd8, 1'b0);
    send_word(64'h0000_0000_0000_0A38, 1'b0);
    wait_idle();
    send_word(64'h0000_0000_000D_0A0A, 1'b0);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("final_in_ready", {63'd0, in_ready}, 1);
    check("final_pending", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
